// File: rtl/vram_write_scheduler_if.sv
// CPU write bus into the scheduler and the deferred commit bus toward addr_decode.
interface vram_write_scheduler_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic          write;
    logic          chipselect;
    logic          commit_we;
    logic [AW-1:0] commit_addr;
    logic [DW-1:0] commit_data;

    modport master (
        output address, write_data, write, chipselect,
        input  commit_we, commit_addr, commit_data
    );

    modport slave (
        input  address, write_data, write, chipselect,
        output commit_we, commit_addr, commit_data
    );
endinterface

// File: rtl/vram_write_scheduler.sv
// Queues CPU VRAM writes and replays them to addr_decode only during vblank.
// Define VBLANK_IRQ_EN to add the vblank interrupt and its clear register at address all-ones.
module vram_write_scheduler #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    vram_write_scheduler_if.slave      bus,
    input  logic                       vblank,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overflow,
    output logic                       frame_done,
    output logic                       irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic          vblank_q;
    logic          vb_rise, is_ctrl, push_req, push, pop, full;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic          commit_we_q;
    logic [AW-1:0] commit_addr_q;
    logic [DW-1:0] commit_data_q;

`ifdef VBLANK_IRQ_EN
    assign is_ctrl = &bus.address;
`else
    assign is_ctrl = 1'b0;
`endif

    assign vb_rise  = vblank & ~vblank_q;
    assign push_req = bus.write & bus.chipselect & ~is_ctrl;
    assign full     = (count_q == CW'(DEPTH));
    // Gated by the live vblank level so nothing commits in the cycle vblank falls.
    assign pop      = (state_q == StDrain) & vblank & (count_q != '0);
    assign push     = push_req & (~full | pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (vb_rise) state_d = StDrain;
            end
            StDrain: begin
                // A push into an empty queue keeps draining so it commits two cycles later.
                if (!vblank) state_d = StIdle;
                else if (count_q == '0 && !push) state_d = StDone;
            end
            StDone: begin
                if (!vblank) state_d = StIdle;
                else if (push) state_d = StDrain;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            vblank_q      <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow      <= 1'b0;
            commit_we_q   <= 1'b0;
            commit_addr_q <= '0;
            commit_data_q <= '0;
        end else begin
            state_q     <= state_d;
            vblank_q    <= vblank;
            count_q     <= count_d;
            commit_we_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q      <= rd_ptr_q + PW'(1);
                commit_addr_q <= mem_addr[rd_ptr_q];
                commit_data_q <= mem_data[rd_ptr_q];
            end
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= bus.address;
            mem_data[wr_ptr_q] <= bus.write_data;
        end
    end

`ifdef VBLANK_IRQ_EN
    logic irq_q;

    // Set has priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (vb_rise) begin
            irq_q <= 1'b1;
        end else if (bus.write && bus.chipselect && is_ctrl) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign bus.commit_we   = commit_we_q;
    assign bus.commit_addr = commit_addr_q;
    assign bus.commit_data = commit_data_q;
    assign pending         = count_q;
    assign frame_done      = (state_q == StDone);

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Randomised and directed bench for vram_write_scheduler against a queue-based reference model.
module tb_vram_write_scheduler;

    localparam int DEPTH = 16;
    localparam int AW    = 12;
    localparam int DW    = 32;
`ifdef VBLANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vblank = 1'b0;
    logic [4:0] pending;
    logic       overflow, frame_done, irq;

    vram_write_scheduler_if #(.AW(AW), .DW(DW)) bus ();

    vram_write_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .vblank     (vblank),
        .pending    (pending),
        .overflow   (overflow),
        .frame_done (frame_done),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of accepted writes plus "drain window active" flag.
    ent_t          q[$];
    bit            m_active, m_vbprev, m_ovf, m_irq, m_we, m_fd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            total = 0;
    int            bad = 0;

    task automatic model_reset();
        q.delete();
        m_active = 0; m_vbprev = 0; m_ovf = 0; m_irq = 0; m_we = 0; m_fd = 0;
        m_addr = '0; m_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.write = 0; bus.chipselect = 0; bus.address = '0; bus.write_data = '0;
        vblank = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, return 1 time unit later.
    task automatic step(input bit wr, input bit cs, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit vb);
        bit   ctrl, req, pop;
        ent_t e;
        bus.write = wr; bus.chipselect = cs; bus.address = a; bus.write_data = d;
        vblank = vb;
        @(posedge clk);
        ctrl = IRQ_EN && (a == 12'hFFF);
        req  = wr && cs && !ctrl;
        pop  = m_active && vb && (q.size() > 0);
        m_fd = m_active && vb && (q.size() == 0) && !req;
        m_we = pop;
        if (pop) begin
            e = q.pop_front();
            m_addr = e.a;
            m_data = e.d;
        end
        if (req) begin
            if (q.size() < DEPTH) begin
                e.a = a; e.d = d;
                q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
        if (IRQ_EN) begin
            if (vb && !m_vbprev) m_irq = 1;
            else if (wr && cs && ctrl) m_irq = 0;
        end
        if (!vb) m_active = 0;
        else if (!m_vbprev) m_active = 1;
        m_vbprev = vb;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.commit_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", bus.commit_we); end
        total++; if (bus.commit_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.commit_addr); end
        total++; if (bus.commit_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.commit_data); end
        total++; if (pending !== 5'd0) begin bad++; $display("FAIL rst_pending got=%0d exp=0", pending); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd got=%b exp=0", frame_done); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    endtask

    task automatic test_queue_and_drain();
        int seen_cyc[$];
        logic [AW-1:0] seen_addr[$];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 12'h010 + 12'(i), $urandom, 0);
            total++; if (bus.commit_we !== 1'b0) begin bad++; $display("FAIL q_we_low got=%b exp=0", bus.commit_we); end
        end
        total++; if (pending !== 5'd3) begin bad++; $display("FAIL q_pending got=%0d exp=3", pending); end
        for (int c = 0; c < 6; c++) begin
            step(0, 0, '0, '0, 1);
            total++;
            if (bus.commit_we !== m_we || bus.commit_data !== m_data) begin
                bad++; $display("FAIL q_commit c=%0d got=%b/%h exp=%b/%h", c, bus.commit_we, bus.commit_data, m_we, m_data);
            end
            if (bus.commit_we === 1'b1) begin
                seen_cyc.push_back(c);
                seen_addr.push_back(bus.commit_addr);
            end
        end
        total++; if (seen_addr.size() != 3) begin bad++; $display("FAIL q_count got=%0d exp=3", seen_addr.size()); end
        for (int i = 0; i < seen_addr.size() && i < 3; i++) begin
            total++;
            if (seen_addr[i] !== 12'h010 + 12'(i) || seen_cyc[i] != i + 1) begin
                bad++; $display("FAIL q_order i=%0d got=%h@%0d exp=%h@%0d", i, seen_addr[i], seen_cyc[i], 12'h010 + 12'(i), i + 1);
            end
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL q_fd got=%b exp=1", frame_done); end
        total++; if (pending !== 5'd0) begin bad++; $display("FAIL q_pending_end got=%0d exp=0", pending); end
    endtask

    task automatic test_overflow();
        int n = 0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 12'h100 + 12'(i), $urandom, 0);
            if (i == 15) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
            end
        end
        total++; if (pending !== 5'd16) begin bad++; $display("FAIL ovf_pending got=%0d exp=16", pending); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int c = 0; c < 20; c++) begin
            step(0, 0, '0, '0, 1);
            if (bus.commit_we === 1'b1) begin
                total++;
                if (bus.commit_addr !== 12'h100 + 12'(n)) begin
                    bad++; $display("FAIL ovf_order n=%0d got=%h exp=%h", n, bus.commit_addr, 12'h100 + 12'(n));
                end
                n++;
            end
        end
        total++; if (n != 16) begin bad++; $display("FAIL ovf_commits got=%0d exp=16", n); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ovf_fd got=%b exp=1", frame_done); end
    endtask

    task automatic test_partial_vblank();
        int n = 0;
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 12'h300 + 12'(i), $urandom, 0);
        // Rising-edge cycle plus four drain cycles.
        for (int c = 0; c < 5; c++) begin
            step(0, 0, '0, '0, 1);
            if (bus.commit_we === 1'b1) begin
                total++;
                if (bus.commit_addr !== 12'h300 + 12'(n)) begin
                    bad++; $display("FAIL part_order n=%0d got=%h exp=%h", n, bus.commit_addr, 12'h300 + 12'(n));
                end
                n++;
            end
        end
        total++; if (n != 4) begin bad++; $display("FAIL part_commits got=%0d exp=4", n); end
        for (int c = 0; c < 6; c++) begin
            step(0, 0, '0, '0, 0);
            total++; if (bus.commit_we !== 1'b0 || pending !== 5'd6) begin
                bad++; $display("FAIL part_hold c=%0d got=%b/%0d exp=0/6", c, bus.commit_we, pending);
            end
        end
        for (int c = 0; c < 10; c++) begin
            step(0, 0, '0, '0, 1);
            if (bus.commit_we === 1'b1) begin
                total++;
                if (bus.commit_addr !== 12'h300 + 12'(n) || bus.commit_data !== m_data) begin
                    bad++; $display("FAIL part_resume n=%0d got=%h exp=%h", n, bus.commit_addr, 12'h300 + 12'(n));
                end
                n++;
            end
        end
        total++; if (n != 10) begin bad++; $display("FAIL part_total got=%0d exp=10", n); end
    endtask

    task automatic test_done_push();
        logic [DW-1:0] d = $urandom;
        do_reset();
        for (int c = 0; c < 3; c++) step(0, 0, '0, '0, 1);
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL done_fd got=%b exp=1", frame_done); end
        step(1, 1, 12'h200, d, 1);
        total++; if (bus.commit_we !== 1'b0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL done_n1 got=%b/%b exp=0/0", bus.commit_we, frame_done);
        end
        step(0, 0, '0, '0, 1);
        total++; if (bus.commit_we !== 1'b1 || bus.commit_addr !== 12'h200 || bus.commit_data !== d) begin
            bad++; $display("FAIL done_commit got=%b/%h/%h exp=1/200/%h", bus.commit_we, bus.commit_addr, bus.commit_data, d);
        end
        step(0, 0, '0, '0, 1);
        total++; if (frame_done !== 1'b1 || bus.commit_we !== 1'b0) begin
            bad++; $display("FAIL done_back got=%b/%b exp=1/0", frame_done, bus.commit_we);
        end
    endtask

    task automatic test_irq();
        do_reset();
        step(0, 0, '0, '0, 0);
        step(0, 0, '0, '0, 1);
        total++; if (irq !== IRQ_EN) begin bad++; $display("FAIL irq_set got=%b exp=%b", irq, IRQ_EN); end
        step(1, 1, 12'hFFF, $urandom, 1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", irq); end
        total++; if (pending !== (IRQ_EN ? 5'd0 : 5'd1)) begin
            bad++; $display("FAIL irq_pending got=%0d exp=%0d", pending, IRQ_EN ? 0 : 1);
        end
        step(0, 0, '0, '0, 1);
        total++; if (bus.commit_we !== !IRQ_EN || (!IRQ_EN && bus.commit_addr !== 12'hFFF)) begin
            bad++; $display("FAIL irq_commit got=%b/%h exp=%b/fff", bus.commit_we, bus.commit_addr, !IRQ_EN);
        end
        step(0, 0, '0, '0, 0);
        step(1, 1, 12'hFFF, $urandom, 1);
        total++; if (irq !== IRQ_EN) begin bad++; $display("FAIL irq_setwins got=%b exp=%b", irq, IRQ_EN); end
        total++; if (irq !== m_irq) begin bad++; $display("FAIL irq_model got=%b exp=%b", irq, m_irq); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 12'h400 + 12'(i), $urandom, 0);
        for (int c = 0; c < 3; c++) step(0, 0, '0, '0, 1);
        total++; if (bus.commit_we !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", bus.commit_we); end
        #2 reset = 1'b1;
        model_reset();
        #1;
        total++; if (bus.commit_we !== 1'b0) begin bad++; $display("FAIL mid_async_we got=%b exp=0", bus.commit_we); end
        total++; if (pending !== 5'd0) begin bad++; $display("FAIL mid_pending got=%0d exp=0", pending); end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(0, 0, '0, '0, 1);
            total++; if (bus.commit_we !== 1'b0 || frame_done !== m_fd) begin
                bad++; $display("FAIL mid_after c=%0d got=%b/%b exp=0/%b", c, bus.commit_we, frame_done, m_fd);
            end
        end
    endtask

    task automatic test_random();
        bit vb = 0;
        int vb_left = 0;
        bit wr, cs;
        logic [AW-1:0] a;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (vb_left == 0) begin
                vb = !vb;
                vb_left = $urandom_range(1, 25);
            end
            vb_left--;
            wr = ($urandom_range(0, 9) < 6);
            cs = ($urandom_range(0, 9) < 8);
            a  = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom);
            step(wr, cs, a, $urandom, vb);
            total++; if (bus.commit_we !== m_we) begin bad++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, bus.commit_we, m_we); end
            total++; if (bus.commit_addr !== m_addr || bus.commit_data !== m_data) begin
                bad++; $display("FAIL rnd_bus c=%0d got=%h/%h exp=%h/%h", c, bus.commit_addr, bus.commit_data, m_addr, m_data);
            end
            total++; if (pending !== 5'(q.size())) begin bad++; $display("FAIL rnd_pending c=%0d got=%0d exp=%0d", c, pending, q.size()); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, overflow, m_ovf); end
            total++; if (frame_done !== m_fd) begin bad++; $display("FAIL rnd_fd c=%0d got=%b exp=%b", c, frame_done, m_fd); end
            total++; if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, irq, m_irq); end
        end
    endtask

    initial begin
        bus.write = 0; bus.chipselect = 0; bus.address = '0; bus.write_data = '0;
        test_reset();
        test_queue_and_drain();
        test_overflow();
        test_partial_vblank();
        test_done_push();
        test_irq();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
